// File: rtl/wt_cache_pkg.sv
// Write-through cache shared constants: address widths and line geometry.
package wt_cache_pkg;

  localparam int unsigned PLEN                = 64;
  localparam int unsigned DCACHE_LINE_WIDTH   = 128;
  localparam int unsigned DCACHE_OFFSET_WIDTH = $clog2(DCACHE_LINE_WIDTH / 8);

endpackage

// File: rtl/wt_inval_queue.sv
// Coherence invalidation queue: buffers snooped line addresses in a small FIFO,
// merging requests for lines already pending, and feeds them to the cache.
module wt_inval_queue
  import wt_cache_pkg::*;
#(
  parameter int unsigned Depth    = 4,
  parameter int unsigned AddrW    = PLEN,
  parameter int unsigned LineOffW = DCACHE_OFFSET_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             snoop_valid_i,
  input  logic [AddrW-1:0] snoop_addr_i,
  output logic             snoop_ready_o,
  output logic             inval_valid_o,
  output logic [AddrW-1:0] inval_addr_o,
  input  logic             inval_ready_i,
  output logic             coalesced_o,
  output logic             empty_o
);

  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW  = $clog2(Depth) + 1;
  localparam int unsigned LineW = AddrW - LineOffW;

  logic [LineW-1:0] line_q [Depth];
  logic [Depth-1:0] vld_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [PtrW-1:0]  wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             coalesced_q;

  logic [LineW-1:0] snoop_line;
  logic             accept;
  logic             pop;
  logic             push;
  logic             hit;
  logic             unused_low;

  assign snoop_line = snoop_addr_i[AddrW-1:LineOffW];
  assign unused_low = ^snoop_addr_i[LineOffW-1:0];

  assign empty_o       = (count_q == '0);
  assign snoop_ready_o = (count_q != CntW'(Depth));
  assign inval_valid_o = !empty_o;
  assign inval_addr_o  = {line_q[rd_ptr_q], {LineOffW{1'b0}}};
  assign coalesced_o   = coalesced_q;

  assign accept = snoop_valid_i && snoop_ready_o;
  assign pop    = inval_valid_o && inval_ready_i;
  assign push   = accept && !hit;

  // A head entry leaving this cycle must not absorb a new request, otherwise
  // that invalidation would be lost once the head is gone.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (vld_q[i] && (line_q[i] == snoop_line) &&
          !(pop && (PtrW'(i) == rd_ptr_q))) begin
        hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      line_q[wr_ptr_q] <= snoop_line;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      coalesced_q <= 1'b0;
    end else begin
      coalesced_q <= accept && hit;
      if (pop) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PtrW'(1);
      end
      if (push) begin
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: doc/wt_inval_queue.md
WT_INVAL_QUEUE -- requirements
Module: wt_inval_queue

Interface
REQ-001 SHALL have parameter Depth, default 4, number of queued invalidation entries (power of two, >=2).
REQ-002 SHALL have parameter AddrW, default 64, invalidation address width.
REQ-003 SHALL have parameter LineOffW, default wt_cache_pkg::DCACHE_OFFSET_WIDTH, low address bits ignored for line matching.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port snoop_valid_i  input  1  external coherence invalidation request valid.
REQ-007 SHALL have port snoop_addr_i  input  AddrW  physical byte address to invalidate.
REQ-008 SHALL have port snoop_ready_o  output  1  request accepted this cycle when high together with snoop_valid_i.
REQ-009 SHALL have port inval_valid_o  output  1  invalidation presented to the cache subsystem.
REQ-010 SHALL have port inval_addr_o  output  AddrW  line-aligned address, low LineOffW bits zero.
REQ-011 SHALL have port inval_ready_i  input  1  cache subsystem accepts the presented invalidation.
REQ-012 SHALL have port coalesced_o  output  1  single-cycle pulse: accepted request merged into an existing entry.
REQ-013 SHALL have port empty_o  output  1  no entry pending.

Function
REQ-014 SHALL store entries as a circular FIFO: read pointer, write pointer, occupancy counter of width clog2(Depth)+1.
REQ-015 SHALL drive snoop_ready_o = (count != Depth); no bypass of a same-cycle pop when full.
REQ-016 SHALL on accept compare snoop_addr_i[AddrW-1:LineOffW] against all valid entries, excluding the head entry if it pops this cycle.
REQ-017 SHALL on match: not enqueue, assert coalesced_o next cycle, leave count unchanged by the push.
REQ-018 SHALL on no match: write the line address at write pointer, increment write pointer modulo Depth.
REQ-019 SHALL present the head entry: inval_valid_o = !empty, inval_addr_o = head address with low LineOffW bits zero.
REQ-020 SHALL pop on inval_valid_o && inval_ready_i, advancing read pointer modulo Depth.
REQ-021 SHALL hold inval_addr_o stable while inval_valid_o high and inval_ready_i low.
REQ-022 SHALL have no combinational path snoop_* -> inval_*; an entry pushed into an empty queue at edge N is visible after edge N.
REQ-023 SHALL, on simultaneous push (non-coalesced) and pop, leave count unchanged and update both pointers.
REQ-024 SHALL preserve FIFO order of distinct lines; pointers wrap at Depth without loss.

Reset
REQ-025 SHALL asynchronously clear pointers, count, valid bits and coalesced_o on rst_ni low; entry address storage need not reset.
REQ-026 SHALL drive inval_valid_o=0, coalesced_o=0, empty_o=1, snoop_ready_o=1 during and after reset.
REQ-027 SHALL discard all pending entries when reset asserts mid-operation; no invalidation issued after release until a new push.

Structure
REQ-028 SHALL take LineOffW default and address width constants from wt_cache_pkg; no new package types required.
REQ-029 SHALL be a single module with flop-array storage and parallel line-address compare; no sub-module.
REQ-030 SHALL be instantiated between the external coherence source and the cache subsystem inval_addr_i/inval_valid_i/inval_ready_o ports.

Verification
REQ-031 SHALL test: reset, one push 0x8000_1234, inval_ready_i=1 -> inval_valid_o next cycle, inval_addr_o=0x8000_1230 (LineOffW=4), empty_o=1 after pop.
REQ-032 SHALL test: push 0x100, 0x108, 0x200 with inval_ready_i=0 -> second coalesced (pulse), count=2, drain order 0x100,0x200.
REQ-033 SHALL test: Depth=4 fill with distinct lines, inval_ready_i=0 -> snoop_ready_o=0; fifth request held until one pop, then accepted.
REQ-034 SHALL test: head 0x300 popping same cycle as new 0x300 push -> not coalesced, 0x300 reissued.
REQ-035 SHALL test: 10 pushes with continuous pop -> pointer wrap, all 10 addresses issued in order, none lost.
REQ-036 SHALL test: rst_ni low with 3 pending entries -> inval_valid_o=0 immediately, empty_o=1, no issue after release.
